interleaver_pp: RTL

//  Parametrised ROWSxCOLS bit block interleaver/deinterleaver with ping-pong buffering.

---
 rtl/interleaver_pp_pkg.sv | 22 ++
 rtl/interleaver_pp_if.sv | 21 ++
 rtl/interleaver_pp_addr_gen.sv | 60 ++++++
 rtl/interleaver_pp.sv | 94 +++++++++
 4 files changed

// File: rtl/interleaver_pp_pkg.sv
// Shared types for the ping-pong bit interleaver: frame mode and matrix scan order.
package interleaver_pp_pkg;

    typedef enum logic {
        ILV_MODE_INTERLEAVE   = 1'b0,
        ILV_MODE_DEINTERLEAVE = 1'b1
    } ilv_mode_e;

    typedef enum logic {
        ORDER_ROW_MAJOR = 1'b0,
        ORDER_COL_MAJOR = 1'b1
    } ilv_order_e;

    function automatic ilv_order_e wr_order(input ilv_mode_e m);
        return (m == ILV_MODE_INTERLEAVE) ? ORDER_ROW_MAJOR : ORDER_COL_MAJOR;
    endfunction

    function automatic ilv_order_e rd_order(input ilv_mode_e m);
        return (m == ILV_MODE_INTERLEAVE) ? ORDER_COL_MAJOR : ORDER_ROW_MAJOR;
    endfunction

endpackage

// File: rtl/interleaver_pp_if.sv
// Serial bit-stream handshake bundle: input stream, per-frame mode, output stream.
interface interleaver_pp_if;
    logic mode;
    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic out_valid;
    logic out_ready;
    logic out_bit;
    logic out_last;

    modport slave (
        input  mode, in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );

    modport master (
        output mode, in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/interleaver_pp_addr_gen.sv
// Row/column counter pair walking a ROWSxCOLS matrix in row- or column-major order.
module ilv_addr_gen
    import interleaver_pp_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int AW   = $clog2(ROWS * COLS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  ilv_order_e    order_i,
    input  logic          advance_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    assign addr_o = AW'(int'(row_q) * COLS + int'(col_q));
    assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);

    // NOTE: defaults first so every path assigns row_d/col_d and no latch is inferred.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (advance_i) begin
            if (order_i == ORDER_ROW_MAJOR) begin
                if (col_q == COL_MAX) begin
                    col_d = '0;
                    row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end else begin
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                    col_d = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/interleaver_pp.sv
// ROWSxCOLS block interleaver/deinterleaver with two ping-pong frame banks,
// one bit per cycle in and out; the mode is captured per frame on its first bit.
module interleaver_pp
    import interleaver_pp_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input logic             clk_origin,
    input logic             rst,
    interleaver_pp_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);

    logic [N-1:0]  bank_q      [2];
    ilv_mode_e     bank_mode_q [2];
    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic          wr_en, rd_en, wr_first, wr_last, rd_last;
    logic [AW-1:0] wr_addr, rd_addr;
    ilv_order_e    wr_ord, rd_ord;

    assign bus.in_ready  = ~full_q[wr_sel_q];
    assign bus.out_valid = full_q[rd_sel_q];
    assign wr_en         = bus.in_valid & bus.in_ready;
    assign rd_en         = bus.out_valid & bus.out_ready;
    assign wr_first      = (wr_addr == '0);

    // Bit 0 steps the counters too, so its order must come from the live mode input.
    assign wr_ord = wr_first ? wr_order(ilv_mode_e'(bus.mode)) : wr_order(bank_mode_q[wr_sel_q]);
    assign rd_ord = rd_order(bank_mode_q[rd_sel_q]);

    ilv_addr_gen #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_wr_addr (
        .clk_i     (clk_origin),
        .rst_i     (rst),
        .order_i   (wr_ord),
        .advance_i (wr_en),
        .addr_o    (wr_addr),
        .last_o    (wr_last)
    );

    ilv_addr_gen #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_rd_addr (
        .clk_i     (clk_origin),
        .rst_i     (rst),
        .order_i   (rd_ord),
        .advance_i (rd_en),
        .addr_o    (rd_addr),
        .last_o    (rd_last)
    );

    assign bus.out_bit  = bank_q[rd_sel_q][rd_addr];
    assign bus.out_last = bus.out_valid & rd_last;

    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (wr_en && wr_last) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (rd_en && rd_last) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk_origin) begin
        if (rst) begin
            full_q         <= '0;
            wr_sel_q       <= 1'b0;
            rd_sel_q       <= 1'b0;
            bank_mode_q[0] <= ILV_MODE_INTERLEAVE;
            bank_mode_q[1] <= ILV_MODE_INTERLEAVE;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            if (wr_en && wr_first) begin
                bank_mode_q[wr_sel_q] <= ilv_mode_e'(bus.mode);
            end
        end
    end

    // NOTE: bank storage has no reset; cleared full flags already make stale bits unreachable.
    always_ff @(posedge clk_origin) begin
        if (wr_en && !rst) begin
            bank_q[wr_sel_q][wr_addr] <= bus.in_bit;
        end
    end

endmodule
